mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory block port between the instruction cache and the data cache.
- Accepts block-fill requests from both caches, plus an optional dirty-block writeback from the data cache.
- Grants the port round-robin, sequences writeback-then-fill for the data cache, and returns each fill block with a one-cycle done pulse.
- Includes a watchdog that aborts a memory transaction that never acknowledges.

Parameters:
ADDR, 32, address width in bits
BLCK, 256, block width in bits (8 << 5)
OFST, 5, block offset bits; mem_addr is block-aligned (low OFST bits forced to 0)
TMO, 64, watchdog limit in cycles waiting for mem_ack (TMO >= 2)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
i_req  in  1  I$ fill request; held high until i_done
i_addr  in  ADDR  I$ miss address
i_done  out  1  one-cycle pulse; i_block valid in the same cycle
i_block  out  BLCK  fill data to I$
d_req  in  1  D$ fill request; held high until d_done
d_addr  in  ADDR  D$ miss address
d_wb  in  1  D$ victim is dirty; sampled at grant
d_wb_addr  in  ADDR  victim block address
d_wb_block  in  BLCK  victim block data
d_done  out  1  one-cycle pulse; d_block valid in the same cycle
d_block  out  BLCK  fill data to D$
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = block write, 0 = block read
mem_addr  out  ADDR  block-aligned address
mem_wdata  out  BLCK  write data
mem_ack  in  1  one-cycle completion; mem_rdata valid for reads
mem_rdata  in  BLCK  read data
err  out  1  sticky watchdog flag; cleared only by RESET

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - state=IDLE; last_gnt=D (so the I$ wins the first tie); watchdog counter=0.
  - All outputs 0: mem_req, mem_we, i_done, d_done, err; block and address outputs also 0.
  - Reset mid-transaction drops the transaction immediately; no done pulse is issued.
- States: IDLE, I_FILL, D_WB, D_FILL, RESP_I, RESP_D.
- IDLE:
  - Only i_req → I_FILL.
  - Only d_req → D_WB if d_wb, else D_FILL.
  - Both → grant the requester not in last_gnt. last_gnt updates on grant.
  - mem_req asserts in the cycle after the grant decision (registered output).
- D_WB:
  - d_wb_addr and d_wb_block are latched at grant.
  - mem_req=1, mem_we=1, mem_addr = d_wb_addr with low OFST bits cleared.
  - On mem_ack → D_FILL; mem_req drops for exactly one cycle between the write and the read.
- I_FILL / D_FILL:
  - mem_req=1, mem_we=0; mem_addr is the aligned address latched at grant.
  - On mem_ack: capture mem_rdata into the requester's block register → RESP_I / RESP_D.
- RESP_x:
  - x_done=1 for one cycle, then → IDLE.
  - A requester must drop req in the cycle after done. A req still high when back in IDLE is treated as a new request.
- Latency: from i_req rising in IDLE to i_done = 3 cycles + memory latency (cycles from mem_req high to mem_ack).
- Block outputs hold their last value until the next fill for that requester.
- Watchdog:
  - The counter increments every cycle mem_req=1 without mem_ack, and clears on mem_ack or on leaving the state.
  - When the count reaches TMO-1: set err, drop mem_req, go to IDLE with no done pulse. The requester may re-request.
- Edge cases:
  - mem_ack in IDLE or RESP_x is ignored.
  - A req deasserted mid-transaction does not abort it; done still pulses.
  - d_wb is ignored unless it is sampled in the grant cycle.
  - Address inputs are captured only at grant; later changes are ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum (3-bit encoding: IDLE=0, I_FILL=1, D_WB=2, D_FILL=3, RESP_I=4, RESP_D=5).
  - Grant id constants GNT_I=0, GNT_D=1.
  - A function for block-address alignment.
- One natural sub-module, mem_arb_watchdog: counter, TMO compare and sticky err, with inputs active/ack and outputs expire/err.

Test Plan:
- i_req only, addr 0x0000_1234, memory ack at 2 cycles with rdata=0xA5..A5 → mem_addr=0x0000_1220, mem_we=0; i_done pulses 5 cycles after i_req with i_block=0xA5..A5.
- i_req and d_req raised the same cycle after reset → I$ served first, then D$; d_done follows the second mem_ack; no overlap of mem_req.
- d_req with d_wb=1, d_wb_addr 0x0000_4040, d_addr 0x0000_8000 → write to 0x0000_4040 carrying d_wb_block, one idle cycle, read from 0x0000_8000, then a single d_done.
- Both requesters held continuously for 6 transactions → grants alternate I, D, I, D, I, D.
- mem_ack never arrives, TMO=64 → mem_req drops after 64 cycles, err=1 and stays 1, no done; a next i_req still completes normally.
- RESET asserted mid D_FILL → next cycle all outputs 0 and IDLE; a late mem_ack is ignored; no done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I$/D$ main-memory arbiter.
// Holds the FSM state encoding, grant identifiers and block alignment.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_FILL = 3'd1,
        D_WB   = 3'd2,
        D_FILL = 3'd3,
        RESP_I = 3'd4,
        RESP_D = 3'd5
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int MAX_ADDR = 64;

    // Clears the block-offset bits; callers narrow the result to their width.
    function automatic logic [MAX_ADDR-1:0] align_block(input logic [MAX_ADDR-1:0] addr,
                                                        input int ofst);
        logic [MAX_ADDR-1:0] mask;
        mask = {MAX_ADDR{1'b1}} << ofst;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache request/response signals and the memory block port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
    parameter int ADDR = 32,
    parameter int BLCK = 256
);
    import mem_arb_pkg::*;

    logic            i_req;
    logic [ADDR-1:0] i_addr;
    logic            i_done;
    logic [BLCK-1:0] i_block;

    logic            d_req;
    logic [ADDR-1:0] d_addr;
    logic            d_wb;
    logic [ADDR-1:0] d_wb_addr;
    logic [BLCK-1:0] d_wb_block;
    logic            d_done;
    logic [BLCK-1:0] d_block;

    logic            mem_req;
    logic            mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [BLCK-1:0] mem_wdata;
    logic            mem_ack;
    logic [BLCK-1:0] mem_rdata;

    logic            err;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wb, d_wb_addr, d_wb_block,
               mem_ack, mem_rdata,
        output i_done, i_block, d_done, d_block,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wb, d_wb_addr, d_wb_block,
               mem_ack, mem_rdata,
        input  i_done, i_block, d_done, d_block,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts cycles a memory request waits for its acknowledge and flags a timeout.
// err is sticky until RESET.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TMO = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic active,
    input  logic ack,
    output logic expire,
    output logic err
);

    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TMO - 1);

    logic [CW-1:0] count;

    assign expire = active && !ack && (count == LIMIT);

    // The count restarts whenever the request is absent, answered or abandoned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (!active || ack || expire) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between I$ and D$,
// with writeback-before-fill sequencing for the D$ and a request watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int BLCK = 256,
    parameter int OFST = 5,
    parameter int TMO  = 64
) (
    input  logic CLK,
    input  logic RESET,
    mem_arbiter_if.slave bus
);

    arb_state_e      state, state_n;
    logic            last_gnt, last_gnt_n;
    logic            mem_req_q, mem_req_n;
    logic            mem_we_q, mem_we_n;
    logic [ADDR-1:0] mem_addr_q, mem_addr_n;
    logic [BLCK-1:0] mem_wdata_q, mem_wdata_n;
    logic [ADDR-1:0] fill_addr_q, fill_addr_n;
    logic [BLCK-1:0] i_block_q, i_block_n;
    logic [BLCK-1:0] d_block_q, d_block_n;
    logic            ack;
    logic            expire;
    logic            wd_err;

    function automatic logic [ADDR-1:0] aligned(input logic [ADDR-1:0] a);
        return ADDR'(align_block(MAX_ADDR'(a), OFST));
    endfunction

    // An acknowledge only counts while a request is actually on the port.
    assign ack = mem_req_q && bus.mem_ack;

    mem_arb_watchdog #(.TMO(TMO)) u_watchdog (
        .CLK    (CLK),
        .RESET  (RESET),
        .active (mem_req_q),
        .ack    (ack),
        .expire (expire),
        .err    (wd_err)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            last_gnt    <= GNT_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_addr_q <= '0;
            i_block_q   <= '0;
            d_block_q   <= '0;
        end else begin
            state       <= state_n;
            last_gnt    <= last_gnt_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            fill_addr_q <= fill_addr_n;
            i_block_q   <= i_block_n;
            d_block_q   <= d_block_n;
        end
    end

    // Port addresses and write data are loaded at grant; mem_req follows a cycle later,
    // which also yields the one-cycle gap between a writeback and its fill.
    always_comb begin
        state_n     = state;
        last_gnt_n  = last_gnt;
        mem_req_n   = mem_req_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        fill_addr_n = fill_addr_q;
        i_block_n   = i_block_q;
        d_block_n   = d_block_q;

        case (state)
            IDLE: begin
                mem_req_n = 1'b0;
                if (bus.i_req && (!bus.d_req || last_gnt == GNT_D)) begin
                    state_n    = I_FILL;
                    last_gnt_n = GNT_I;
                    mem_we_n   = 1'b0;
                    mem_addr_n = aligned(bus.i_addr);
                end else if (bus.d_req) begin
                    last_gnt_n  = GNT_D;
                    fill_addr_n = aligned(bus.d_addr);
                    if (bus.d_wb) begin
                        state_n     = D_WB;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = aligned(bus.d_wb_addr);
                        mem_wdata_n = bus.d_wb_block;
                    end else begin
                        state_n    = D_FILL;
                        mem_we_n   = 1'b0;
                        mem_addr_n = aligned(bus.d_addr);
                    end
                end
            end
            I_FILL, D_WB, D_FILL: begin
                if (expire) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                end else if (ack) begin
                    mem_req_n = 1'b0;
                    if (state == I_FILL) begin
                        i_block_n = bus.mem_rdata;
                        state_n   = RESP_I;
                    end else if (state == D_WB) begin
                        state_n    = D_FILL;
                        mem_we_n   = 1'b0;
                        mem_addr_n = fill_addr_q;
                    end else begin
                        d_block_n = bus.mem_rdata;
                        state_n   = RESP_D;
                    end
                end else begin
                    mem_req_n = 1'b1;
                end
            end
            RESP_I, RESP_D: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    assign bus.i_done    = (state == RESP_I);
    assign bus.d_done    = (state == RESP_D);
    assign bus.i_block   = i_block_q;
    assign bus.d_block   = d_block_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = wd_err;

endmodule
